// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The default address width matches the pipeline PC width.
package imem_loader_pkg;

   localparam int INSTR_W     = 32;
   localparam int IMEM_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Byte lane inside the 32-bit word for the idx-th byte of the stream.
   function automatic logic [1:0] byte_lane(input logic [1:0] idx, input logic big_endian);
      return big_endian ? ~idx : idx;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader takes the slave view, the stream source/memory side takes master.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
);

   logic                 ld_in_start;
   logic [ADDR_W:0]      ld_in_len;
   logic [7:0]           ld_in_byte;
   logic                 ld_in_byte_valid;
   logic                 ld_out_byte_ready;
   logic [ADDR_W-1:0]    ld_out_mem_addr;
   logic [INSTR_W-1:0]   ld_out_mem_data;
   logic                 ld_out_mem_wren;
   logic                 ld_out_busy;
   logic                 ld_out_done;
   logic                 ld_out_cpu_run;
   logic [ADDR_W:0]      ld_out_word_count;
   logic [7:0]           ld_out_checksum;

   modport slave (
      input  ld_in_start, ld_in_len, ld_in_byte, ld_in_byte_valid,
      output ld_out_byte_ready, ld_out_mem_addr, ld_out_mem_data, ld_out_mem_wren,
             ld_out_busy, ld_out_done, ld_out_cpu_run, ld_out_word_count, ld_out_checksum
   );

   modport master (
      output ld_in_start, ld_in_len, ld_in_byte, ld_in_byte_valid,
      input  ld_out_byte_ready, ld_out_mem_addr, ld_out_mem_data, ld_out_mem_wren,
             ld_out_busy, ld_out_done, ld_out_cpu_run, ld_out_word_count, ld_out_checksum
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into a 32-bit word and keeps a running XOR checksum.
// o_word_full flags the accept that completes the current word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_accept,
   input  logic               i_clear,
   input  logic               i_clear_sum,
   input  logic [7:0]         i_byte,
   output logic [INSTR_W-1:0] o_word,
   output logic               o_word_full,
   output logic [7:0]         o_checksum
);

   logic [1:0]         r_idx;
   logic [INSTR_W-1:0] r_word;
   logic [7:0]         r_checksum;
   logic [1:0]         w_lane;

   assign w_lane      = byte_lane(r_idx, BIG_ENDIAN);
   assign o_word_full = i_accept && (r_idx == 2'd3);
   assign o_word      = r_word;
   assign o_checksum  = r_checksum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= 2'd0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx  <= 2'd0;
         r_word <= '0;
      end else if (i_accept) begin
         r_word[{w_lane, 3'b000} +: 8] <= i_byte;
         r_idx                         <= r_idx + 2'd1;
      end
   end

   // The checksum spans the whole session, so only a new session clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_checksum <= 8'h00;
      end else if (i_clear_sum) begin
         r_checksum <= 8'h00;
      end else if (i_accept) begin
         r_checksum <= r_checksum ^ i_byte;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, one 32-bit word write per 4 bytes,
// CPU held out of run until the requested number of words has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W     = IMEM_ADDR_W,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic          ld_in_clk,
   input  logic          ld_in_rst,
   imem_loader_if.slave  bus
);

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W:0]    r_len_eff;
   logic [ADDR_W:0]    r_word_count;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               r_cpu_run;
   logic               r_wren;

   logic [ADDR_W:0]    w_len_eff;
   logic [ADDR_W:0]    w_count_inc;
   logic               w_start_ok;
   logic               w_accept;
   logic               w_word_full;
   logic               w_last_word;
   logic               w_clear;
   logic [INSTR_W-1:0] w_word;
   logic [7:0]         w_checksum;

   // Any length of 2^ADDR_W or more saturates so the address never wraps.
   assign w_len_eff   = bus.ld_in_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : bus.ld_in_len;
   assign w_count_inc = r_word_count + {{ADDR_W{1'b0}}, 1'b1};
   assign w_start_ok  = bus.ld_in_start && ((r_state == IDLE) || (r_state == DONE));
   assign w_accept    = r_ready && bus.ld_in_byte_valid;
   assign w_last_word = (w_count_inc == r_len_eff);
   assign w_clear     = w_start_ok || (r_state == WRITE);

   imem_loader_byte_packer #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_packer (
      .clk         (ld_in_clk),
      .rst_n       (ld_in_rst),
      .i_accept    (w_accept),
      .i_clear     (w_clear),
      .i_clear_sum (w_start_ok),
      .i_byte      (bus.ld_in_byte),
      .o_word      (w_word),
      .o_word_full (w_word_full),
      .o_checksum  (w_checksum)
   );

   always_ff @(posedge ld_in_clk or negedge ld_in_rst) begin
      if (!ld_in_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, DONE: begin
            if (w_start_ok) begin
               w_next = (w_len_eff == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (w_word_full) begin
               w_next = WRITE;
            end
         end
         WRITE: begin
            w_next = w_last_word ? DONE : COLLECT;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge ld_in_clk or negedge ld_in_rst) begin
      if (!ld_in_rst) begin
         r_len_eff    <= '0;
         r_word_count <= '0;
      end else if (w_start_ok) begin
         r_len_eff    <= w_len_eff;
         r_word_count <= '0;
      end else if (r_state == WRITE) begin
         r_word_count <= w_count_inc;
      end
   end

   // Status outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge ld_in_clk or negedge ld_in_rst) begin
      if (!ld_in_rst) begin
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cpu_run <= 1'b0;
         r_wren    <= 1'b0;
      end else begin
         r_ready   <= (w_next == COLLECT);
         r_busy    <= (w_next == COLLECT) || (w_next == WRITE);
         r_done    <= (w_next == DONE);
         r_cpu_run <= (w_next == DONE);
         r_wren    <= (w_next == WRITE);
      end
   end

   assign bus.ld_out_byte_ready = r_ready;
   assign bus.ld_out_mem_addr   = r_word_count[ADDR_W-1:0];
   assign bus.ld_out_mem_data   = w_word;
   assign bus.ld_out_mem_wren   = r_wren;
   assign bus.ld_out_busy       = r_busy;
   assign bus.ld_out_done       = r_done;
   assign bus.ld_out_cpu_run    = r_cpu_run;
   assign bus.ld_out_word_count = r_word_count;
   assign bus.ld_out_checksum   = w_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a big-endian and a little-endian instance share one stream.
// Writes are captured into a memory image per instance and compared with hand-computed words.
module tb_imem_loader;

   localparam int AW = 10;

   typedef struct {
      logic [31:0] stream;
      logic [31:0] expBe;
      logic [31:0] expLe;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW:0]   len;
   logic [7:0]    dataByte;
   logic          valid;

   int            compared;
   int            mismatched;
   int            wrCountBe;
   int            wrCountLe;
   int            lastAddrBe;
   logic [31:0]   imemBe [1024];
   logic [31:0]   imemLe [1024];
   vec_t          vecs [3];

   imem_loader_if #(.ADDR_W(AW)) beIf ();
   imem_loader_if #(.ADDR_W(AW)) leIf ();

   imem_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dutBe (
      .ld_in_clk (clk),
      .ld_in_rst (rst_n),
      .bus       (beIf.slave)
   );

   imem_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b0)) dutLe (
      .ld_in_clk (clk),
      .ld_in_rst (rst_n),
      .bus       (leIf.slave)
   );

   assign beIf.ld_in_start      = start;
   assign beIf.ld_in_len        = len;
   assign beIf.ld_in_byte       = dataByte;
   assign beIf.ld_in_byte_valid = valid;
   assign leIf.ld_in_start      = start;
   assign leIf.ld_in_len        = len;
   assign leIf.ld_in_byte       = dataByte;
   assign leIf.ld_in_byte_valid = valid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory images built from observed writes, sampled mid-cycle.
   always @(negedge clk) begin
      if (beIf.ld_out_mem_wren) begin
         imemBe[beIf.ld_out_mem_addr] = beIf.ld_out_mem_data;
         lastAddrBe = int'(beIf.ld_out_mem_addr);
         wrCountBe++;
      end
      if (leIf.ld_out_mem_wren) begin
         imemLe[leIf.ld_out_mem_addr] = leIf.ld_out_mem_data;
         wrCountLe++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Presents one byte after 'gap' idle cycles and holds it until accepted; called at posedge+1.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int  n;
      logic acc;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      dataByte = b;
      valid    = 1'b1;
      n        = 0;
      acc      = 1'b0;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = beIf.ld_out_byte_ready;
         @(posedge clk);
         #1;
         n++;
      end
      valid = 1'b0;
      if (!acc) checkOutput("byteAcceptTimeout", 32'(acc), 32'd1);
   endtask

   task automatic startSession(input logic [AW:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int bound);
      int n;
      n = 0;
      while (!beIf.ld_out_done && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("doneReached", 32'(beIf.ld_out_done), 32'd1);
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int wrBase;
      compared   = 0;
      mismatched = 0;
      wrCountBe  = 0;
      wrCountLe  = 0;
      lastAddrBe = -1;
      start      = 1'b0;
      len        = '0;
      dataByte   = 8'h00;
      valid      = 1'b0;
      rst_n      = 1'b0;

      vecs[0] = '{32'h12345678, 32'h12345678, 32'h78563412};
      vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE};
      vecs[2] = '{32'h0180FF00, 32'h0180FF00, 32'h00FF8001};

      $display("[TB] reset state");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstReady",     32'(beIf.ld_out_byte_ready), 32'd0);
      checkOutput("rstBusy",      32'(beIf.ld_out_busy),       32'd0);
      checkOutput("rstDone",      32'(beIf.ld_out_done),       32'd0);
      checkOutput("rstCpuRun",    32'(beIf.ld_out_cpu_run),    32'd0);
      checkOutput("rstWren",      32'(beIf.ld_out_mem_wren),   32'd0);
      checkOutput("rstWordCount", 32'(beIf.ld_out_word_count), 32'd0);
      checkOutput("rstChecksum",  32'(beIf.ld_out_checksum),   32'd0);
      checkOutput("rstData",      beIf.ld_out_mem_data,        32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] zero-length session");
      startSession(11'd0);
      checkOutput("len0Done",      32'(beIf.ld_out_done),       32'd1);
      checkOutput("len0CpuRun",    32'(beIf.ld_out_cpu_run),    32'd1);
      checkOutput("len0Busy",      32'(beIf.ld_out_busy),       32'd0);
      checkOutput("len0WordCount", 32'(beIf.ld_out_word_count), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("len0NoWrite",   32'(wrCountBe),              32'd0);

      $display("[TB] two-word session");
      wrBase = wrCountBe;
      startSession(11'd2);
      checkOutput("cpuRunDrop", 32'(beIf.ld_out_cpu_run), 32'd0);
      checkOutput("busyHigh",   32'(beIf.ld_out_busy),    32'd1);
      applyStimulus(8'h20, 0);
      applyStimulus(8'h08, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h05, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      waitDone(10);
      checkOutput("s2Writes",    32'(wrCountBe - wrBase),     32'd2);
      checkOutput("s2Be0",       imemBe[0],                   32'h20080005);
      checkOutput("s2Be1",       imemBe[1],                   32'h00000000);
      checkOutput("s2Le0",       imemLe[0],                   32'h05000820);
      checkOutput("s2Le1",       imemLe[1],                   32'h00000000);
      checkOutput("s2CpuRun",    32'(beIf.ld_out_cpu_run),    32'd1);
      checkOutput("s2WordCount", 32'(beIf.ld_out_word_count), 32'd2);
      checkOutput("s2Checksum",  32'(beIf.ld_out_checksum),   32'h2D);

      $display("[TB] table session");
      wrBase = wrCountBe;
      startSession(11'd3);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) begin
            applyStimulus(vecs[k].stream[31 - 8*j -: 8], j % 2);
         end
      end
      waitDone(10);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("tblBe%0d", k), imemBe[k], vecs[k].expBe);
         checkOutput($sformatf("tblLe%0d", k), imemLe[k], vecs[k].expLe);
      end
      checkOutput("tblWrites",   32'(wrCountBe - wrBase),     32'd3);
      checkOutput("tblChecksum", 32'(beIf.ld_out_checksum),   32'h54);

      $display("[TB] gaps, held byte through write, start while busy");
      wrBase = wrCountBe;
      startSession(11'd2);
      applyStimulus(8'hA1, 2);
      applyStimulus(8'hB2, 0);
      startSession(11'd0);
      checkOutput("ignStartBusy", 32'(beIf.ld_out_busy), 32'd1);
      checkOutput("ignStartDone", 32'(beIf.ld_out_done), 32'd0);
      applyStimulus(8'hC3, 3);
      applyStimulus(8'hD4, 1);
      dataByte = 8'h11;
      valid    = 1'b1;
      @(negedge clk);
      checkOutput("heldWren",  32'(beIf.ld_out_mem_wren),   32'd1);
      checkOutput("heldReady", 32'(beIf.ld_out_byte_ready), 32'd0);
      checkOutput("heldAddr",  32'(beIf.ld_out_mem_addr),   32'd0);
      @(posedge clk);
      #1;
      checkOutput("heldReadyBack", 32'(beIf.ld_out_byte_ready), 32'd1);
      checkOutput("heldWrenLow",   32'(beIf.ld_out_mem_wren),   32'd0);
      checkOutput("heldCount",     32'(beIf.ld_out_word_count), 32'd1);
      checkOutput("heldSumBefore", 32'(beIf.ld_out_checksum),   32'h04);
      @(posedge clk);
      #1;
      valid = 1'b0;
      checkOutput("heldSumAfter",  32'(beIf.ld_out_checksum),   32'h15);
      applyStimulus(8'h22, 0);
      applyStimulus(8'h33, 0);
      applyStimulus(8'h44, 0);
      waitDone(10);
      checkOutput("gapBe0",      imemBe[0],                   32'hA1B2C3D4);
      checkOutput("gapBe1",      imemBe[1],                   32'h11223344);
      checkOutput("gapLe0",      imemLe[0],                   32'hD4C3B2A1);
      checkOutput("gapWrites",   32'(wrCountBe - wrBase),     32'd2);
      checkOutput("gapWordCnt",  32'(beIf.ld_out_word_count), 32'd2);
      checkOutput("gapChecksum", 32'(beIf.ld_out_checksum),   32'h40);

      $display("[TB] reset mid-word");
      wrBase = wrCountBe;
      startSession(11'd2);
      applyStimulus(8'hAA, 0);
      applyStimulus(8'hBB, 0);
      applyStimulus(8'hCC, 0);
      checkOutput("midSum", 32'(beIf.ld_out_checksum), 32'hDD);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncBusy",  32'(beIf.ld_out_busy),       32'd0);
      checkOutput("asyncReady", 32'(beIf.ld_out_byte_ready), 32'd0);
      checkOutput("asyncSum",   32'(beIf.ld_out_checksum),   32'd0);
      checkOutput("asyncData",  beIf.ld_out_mem_data,        32'd0);
      checkOutput("asyncDone",  32'(beIf.ld_out_done),       32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstNoWrite", 32'(wrCountBe - wrBase), 32'd0);

      $display("[TB] saturated length");
      wrBase = wrCountBe;
      startSession(11'd2000);
      for (int i = 0; i < 4096; i++) begin
         applyStimulus(8'(i), 0);
      end
      waitDone(10);
      checkOutput("satWrites",   32'(wrCountBe - wrBase),     32'd1024);
      checkOutput("satLastAddr", 32'(lastAddrBe),             32'd1023);
      checkOutput("satBeFirst",  imemBe[0],                   32'h00010203);
      checkOutput("satBeLast",   imemBe[1023],                32'hFCFDFEFF);
      checkOutput("satLeLast",   imemLe[1023],                32'hFFFEFDFC);
      checkOutput("satWordCnt",  32'(beIf.ld_out_word_count), 32'd1024);
      checkOutput("satCpuRun",   32'(beIf.ld_out_cpu_run),    32'd1);
      checkOutput("satChecksum", 32'(beIf.ld_out_checksum),   32'h00);
      checkOutput("satLeWrites", 32'(wrCountLe),              32'(wrCountBe));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
